// File: rtl/addsub_acc_pkg.sv
// Shared encodings for the add/sub accumulator stage: command codes and result-register FSM states.
package addsub_acc_pkg;

    typedef enum logic [1:0] {
        CMD_ACC   = 2'b00,
        CMD_LOAD  = 2'b01,
        CMD_CLEAR = 2'b10,
        CMD_HOLD  = 2'b11
    } cmd_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

endpackage

// File: rtl/fullAdderNb.sv
// N-bit ripple add/sub: sum = a + (b ^ {cin}) + cin; cin=1 gives a-b. Purely combinational.
// v is signed overflow, taken as carry-into-MSB xor carry-out.
module fullAdderNb #(
    parameter int Width = 8
) (
    input  logic [Width-1:0] a,
    input  logic [Width-1:0] b,
    input  logic             cin,
    output logic [Width-1:0] sum,
    output logic             cout,
    output logic             v
);

    logic [Width-1:0] b_eff;
    logic             carry;
    logic             carry_msb;

    assign b_eff = b ^ {Width{cin}};

    always_comb begin
        sum       = '0;
        carry     = cin;
        carry_msb = 1'b0;
        for (int i = 0; i < Width; i++) begin
            if (i == Width - 1) carry_msb = carry;
            sum[i] = a[i] ^ b_eff[i] ^ carry;
            carry  = (a[i] & b_eff[i]) | (a[i] & carry) | (b_eff[i] & carry);
        end
    end

    assign cout = carry;
    assign v    = carry ^ carry_msb;

endmodule

// File: rtl/addsub_acc_ctrl.sv
// Accumulator stage around fullAdderNb; one registered result, latency 1 from accept.
// Backpressure: in_ready = !out_valid | out_ready, so a full-throughput stream sees no bubble.
module addsub_acc_ctrl
    import addsub_acc_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CNT_W    = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_cmd,
    input  logic             in_op,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_acc,
    output logic             out_c,
    output logic             out_v,
    output logic             out_z,
    output logic             out_n,
    output logic             sticky_v,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [WIDTH-1:0] ACC_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] ACC_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             c_q, c_d;
    logic             v_q, v_d;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic             add_v;
    logic             accept;

    fullAdderNb #(.Width(WIDTH)) u_adder (
        .a    (acc_q),
        .b    (in_data),
        .cin  (in_op),
        .sum  (add_sum),
        .cout (add_cout),
        .v    (add_v)
    );

    assign out_valid = (state_q == ST_FULL);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        c_d      = c_q;
        v_d      = v_q;
        sticky_d = sticky_q;
        cnt_d    = cnt_q;

        case (state_q)
            ST_EMPTY: if (accept) state_d = ST_FULL;
            ST_FULL:  if (out_ready && !in_valid) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase

        if (accept) begin
            case (cmd_e'(in_cmd))
                CMD_ACC: begin
                    // On overflow the accumulator's own sign tells which rail was crossed.
                    if (SATURATE && add_v) acc_d = acc_q[WIDTH-1] ? ACC_MIN : ACC_MAX;
                    else                   acc_d = add_sum;
                    c_d      = add_cout;
                    v_d      = add_v;
                    sticky_d = sticky_q | add_v;
                    if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                end
                CMD_LOAD: begin
                    acc_d    = in_data;
                    c_d      = 1'b0;
                    v_d      = 1'b0;
                    sticky_d = 1'b0;
                    cnt_d    = '0;
                end
                CMD_CLEAR: begin
                    acc_d    = '0;
                    c_d      = 1'b0;
                    v_d      = 1'b0;
                    sticky_d = 1'b0;
                    cnt_d    = '0;
                end
                default: begin
                    c_d = 1'b0;
                    v_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_EMPTY;
            acc_q    <= '0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            c_q      <= c_d;
            v_q      <= v_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign out_acc  = acc_q;
    assign out_c    = c_q;
    assign out_v    = v_q;
    assign out_z    = (acc_q == '0);
    assign out_n    = acc_q[WIDTH-1];
    assign sticky_v = sticky_q;
    assign op_count = cnt_q;

endmodule
